// File: rtl/vga_test_pattern_if.sv
// VGA pin bundle for the DE10-Lite 12-bit DAC plus the frame-counter LEDs.
// The pattern generator drives it via the master modport; observers use slave.
interface vga_test_pattern_if;
   logic [3:0] VGA_R;
   logic [3:0] VGA_G;
   logic [3:0] VGA_B;
   logic       VGA_HS;
   logic       VGA_VS;
   logic [9:0] LEDR;

   modport master (output VGA_R, output VGA_G, output VGA_B,
                   output VGA_HS, output VGA_VS, output LEDR);
   modport slave  (input VGA_R, input VGA_G, input VGA_B,
                   input VGA_HS, input VGA_VS, input LEDR);
endinterface

// File: rtl/vga_test_pattern.sv
// Free-running VGA timing generator painting eight vertical colour bars.
// Sync and colour are both registered from the same counter snapshot, so they
// share a one-cycle latency and stay aligned. LEDR shows a 10-bit frame count.
module vga_test_pattern #(
   parameter int   H_VISIBLE_AREA = 800,
   parameter int   H_FRONT_PORCH  = 40,
   parameter int   H_SYNC_PULSE   = 128,
   parameter int   H_BACK_PORCH   = 88,
   parameter int   V_VISIBLE_AREA = 600,
   parameter int   V_FRONT_PORCH  = 1,
   parameter int   V_SYNC_PULSE   = 4,
   parameter int   V_BACK_PORCH   = 23,
   parameter logic HSYNC_POLARITY = 1'b0,
   parameter logic VSYNC_POLARITY = 1'b0
) (
   input  logic                VGA_CLK,
   input  logic                RESET,
   vga_test_pattern_if.master  vga
);

   localparam int H_TOTAL = H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
   localparam int V_TOTAL = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;

   localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS      = 11'(H_VISIBLE_AREA);
   localparam logic [10:0] V_VIS      = 11'(V_VISIBLE_AREA);
   localparam logic [10:0] HS_START   = 11'(H_VISIBLE_AREA + H_FRONT_PORCH);
   localparam logic [10:0] HS_END     = 11'(H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE);
   localparam logic [10:0] VS_START   = 11'(V_VISIBLE_AREA + V_FRONT_PORCH);
   localparam logic [10:0] VS_END     = 11'(V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE);
   localparam logic [10:0] BAR_WIDTH  = 11'(H_VISIBLE_AREA / 8);

   logic [10:0] r_h_count;
   logic [10:0] r_v_count;
   logic [9:0]  r_frame_count;

   logic [3:0]  r_red;
   logic [3:0]  r_green;
   logic [3:0]  r_blue;
   logic        r_hsync;
   logic        r_vsync;

   logic [10:0] w_bar_full;
   logic [2:0]  w_bar;
   logic        w_visible;
   logic        w_hs_active;
   logic        w_vs_active;
   logic [11:0] w_colour;

   // Bar palette as packed {R,G,B}; each channel is fully on or off.
   function automatic logic [11:0] bar_colour(input logic [2:0] idx);
      logic [11:0] rgb;
      case (idx)
         3'd0:    rgb = 12'hFFF;   // white
         3'd1:    rgb = 12'hFF0;   // yellow
         3'd2:    rgb = 12'h0FF;   // cyan
         3'd3:    rgb = 12'h0F0;   // green
         3'd4:    rgb = 12'hF0F;   // magenta
         3'd5:    rgb = 12'hF00;   // red
         3'd6:    rgb = 12'h00F;   // blue
         default: rgb = 12'h000;   // black
      endcase
      return rgb;
   endfunction

   // Pixel and line counters; frame counter advances on the full-frame wrap.
   always_ff @(posedge VGA_CLK or posedge RESET) begin
      if (RESET) begin
         r_h_count     <= '0;
         r_v_count     <= '0;
         r_frame_count <= '0;
      end else if (r_h_count == H_LAST) begin
         r_h_count <= '0;
         if (r_v_count == V_LAST) begin
            r_v_count     <= '0;
            r_frame_count <= r_frame_count + 10'd1;
         end else begin
            r_v_count <= r_v_count + 11'd1;
         end
      end else begin
         r_h_count <= r_h_count + 11'd1;
      end
   end

   // Decode of the current counter snapshot: visibility, sync windows, bar colour.
   always_comb begin
      w_visible   = (r_h_count < H_VIS) && (r_v_count < V_VIS);
      w_hs_active = (r_h_count >= HS_START) && (r_h_count < HS_END);
      w_vs_active = (r_v_count >= VS_START) && (r_v_count < VS_END);
      w_bar_full  = r_h_count / BAR_WIDTH;
      // Leftover pixels when the width is not a multiple of 8 stay in the last bar.
      w_bar       = (w_bar_full > 11'd7) ? 3'd7 : w_bar_full[2:0];
      w_colour    = w_visible ? bar_colour(w_bar) : 12'h000;
   end

   // Register sync and colour together so both carry the same one-cycle latency.
   always_ff @(posedge VGA_CLK or posedge RESET) begin
      if (RESET) begin
         r_red   <= '0;
         r_green <= '0;
         r_blue  <= '0;
         r_hsync <= HSYNC_POLARITY;
         r_vsync <= VSYNC_POLARITY;
      end else begin
         r_red   <= w_colour[11:8];
         r_green <= w_colour[7:4];
         r_blue  <= w_colour[3:0];
         r_hsync <= w_hs_active ? ~HSYNC_POLARITY : HSYNC_POLARITY;
         r_vsync <= w_vs_active ? ~VSYNC_POLARITY : VSYNC_POLARITY;
      end
   end

   assign vga.VGA_R  = r_red;
   assign vga.VGA_G  = r_green;
   assign vga.VGA_B  = r_blue;
   assign vga.VGA_HS = r_hsync;
   assign vga.VGA_VS = r_vsync;
   assign vga.LEDR   = r_frame_count;

endmodule

// File: tb/tb_vga_test_pattern.sv
// Bench for vga_test_pattern: one default-mode instance for line timing and
// two tiny-mode instances (both sync polarities) for frame timing and the
// 1024-frame LED wrap. A linear-pixel-index model is checked every cycle.
`timescale 1ns/1ps
module tb_vga_test_pattern;

   // Tiny mode: 12 clocks per line, 5 lines per frame, 60 clocks per frame.
   localparam int S_HV = 9, S_HFP = 1, S_HSP = 1, S_HBP = 1;
   localparam int S_VV = 2, S_VFP = 1, S_VSP = 1, S_VBP = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n   = 0;        // rising edges since reset release
   int   checks = 0;
   int   errors = 0;

   logic [11:0] COLOURS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                12'hF0F, 12'hF00, 12'h00F, 12'h000};

   vga_test_pattern_if ifa ();
   vga_test_pattern_if ifb ();
   vga_test_pattern_if ifc ();

   vga_test_pattern u_dflt (.VGA_CLK(clk), .RESET(rst), .vga(ifa));

   vga_test_pattern #(
      .H_VISIBLE_AREA(S_HV), .H_FRONT_PORCH(S_HFP), .H_SYNC_PULSE(S_HSP), .H_BACK_PORCH(S_HBP),
      .V_VISIBLE_AREA(S_VV), .V_FRONT_PORCH(S_VFP), .V_SYNC_PULSE(S_VSP), .V_BACK_PORCH(S_VBP)
   ) u_small_pos (.VGA_CLK(clk), .RESET(rst), .vga(ifb));

   vga_test_pattern #(
      .H_VISIBLE_AREA(S_HV), .H_FRONT_PORCH(S_HFP), .H_SYNC_PULSE(S_HSP), .H_BACK_PORCH(S_HBP),
      .V_VISIBLE_AREA(S_VV), .V_FRONT_PORCH(S_VFP), .V_SYNC_PULSE(S_VSP), .V_BACK_PORCH(S_VBP),
      .HSYNC_POLARITY(1'b1), .VSYNC_POLARITY(1'b1)
   ) u_small_neg (.VGA_CLK(clk), .RESET(rst), .vga(ifc));

   always #12.5 clk = ~clk;

   // Packed observation {R,G,B,HS,VS,LEDR}.
   wire [23:0] obs_a = {ifa.VGA_R, ifa.VGA_G, ifa.VGA_B, ifa.VGA_HS, ifa.VGA_VS, ifa.LEDR};
   wire [23:0] obs_b = {ifb.VGA_R, ifb.VGA_G, ifb.VGA_B, ifb.VGA_HS, ifb.VGA_VS, ifb.LEDR};
   wire [23:0] obs_c = {ifc.VGA_R, ifc.VGA_G, ifc.VGA_B, ifc.VGA_HS, ifc.VGA_VS, ifc.LEDR};

   // Expected outputs after edge k: the decode of linear pixel k-1.
   function automatic logic [23:0] model(input int hv, hfp, hsp, hbp, vv, vfp, vsp, vbp,
                                         input logic hp, vp, input int k);
      int ht, vt, p, h, v, bar;
      logic [11:0] rgb;
      logic hs, vs;
      logic [9:0] led;
      ht  = hv + hfp + hsp + hbp;
      vt  = vv + vfp + vsp + vbp;
      p   = k - 1;
      h   = p % ht;
      v   = (p / ht) % vt;
      hs  = (h >= hv + hfp && h < hv + hfp + hsp) ? ~hp : hp;
      vs  = (v >= vv + vfp && v < vv + vfp + vsp) ? ~vp : vp;
      rgb = 12'h000;
      if (h < hv && v < vv) begin
         bar = h / (hv / 8);
         if (bar > 7) bar = 7;
         rgb = COLOURS[bar];
      end
      led = 10'((k / (ht * vt)) % 1024);
      return {rgb, hs, vs, led};
   endfunction

   task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (edge %0d): got %h expected %h", name, n, act, exp);
      end
   endtask

   // Every-cycle comparison against the model, sampled 1 ns after the edge.
   always @(posedge clk) begin
      #1;
      if (rst) begin
         n = 0;
         chk("reset_a", obs_a, {12'h000, 1'b0, 1'b0, 10'd0});
         chk("reset_b", obs_b, {12'h000, 1'b0, 1'b0, 10'd0});
         chk("reset_c", obs_c, {12'h000, 1'b1, 1'b1, 10'd0});
      end else begin
         n++;
         chk("model_a", obs_a, model(800, 40, 128, 88, 600, 1, 4, 23, 1'b0, 1'b0, n));
         chk("model_b", obs_b, model(S_HV, S_HFP, S_HSP, S_HBP, S_VV, S_VFP, S_VSP, S_VBP,
                                     1'b0, 1'b0, n));
         chk("model_c", obs_c, model(S_HV, S_HFP, S_HSP, S_HBP, S_VV, S_VFP, S_VSP, S_VBP,
                                     1'b1, 1'b1, n));
      end
   end

   // Wait (bounded) until the outputs after edge k are stable.
   task automatic wait_n(input int k);
      int guard;
      guard = 0;
      while (n != k && guard < 100000) begin
         @(posedge clk);
         #2;
         guard++;
      end
      checks++;
      if (n != k) begin
         errors++;
         $display("FAIL wait_edge: reached %0d expected %0d", n, k);
      end
   endtask

   initial begin
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Default mode, line 0: colour bars and HSYNC window (literal values).
      wait_n(1);    chk("a_e1_rgb_hs_vs", {obs_a[23:12], ifa.VGA_HS, ifa.VGA_VS}, {12'hFFF, 2'b00});
      wait_n(100);  chk("a_px99_white",   {12'h0, obs_a[23:12]}, {12'h0, 12'hFFF});
      wait_n(101);  chk("a_px100_yellow", {12'h0, obs_a[23:12]}, {12'h0, 12'hFF0});
      wait_n(351);  chk("a_px350_green",  {12'h0, obs_a[23:12]}, {12'h0, 12'h0F0});
      wait_n(451);  chk("a_px450_magenta",{12'h0, obs_a[23:12]}, {12'h0, 12'hF0F});
      wait_n(700);  chk("a_px699_blue",   {12'h0, obs_a[23:12]}, {12'h0, 12'h00F});
      wait_n(800);  chk("a_px799_black",  {12'h0, obs_a[23:12]}, {12'h0, 12'h000});
      wait_n(801);  chk("a_px800_blank",  {12'h0, obs_a[23:12]}, {12'h0, 12'h000});
      wait_n(840);  chk("a_hs_before",    {23'h0, ifa.VGA_HS}, 24'd0);
      wait_n(841);  chk("a_hs_rise",      {23'h0, ifa.VGA_HS}, 24'd1);
      wait_n(968);  chk("a_hs_last",      {23'h0, ifa.VGA_HS}, 24'd1);
      wait_n(969);  chk("a_hs_fall",      {23'h0, ifa.VGA_HS}, 24'd0);
      wait_n(1057); chk("a_line1_px0",    {11'h0, obs_a[23:12], ifa.VGA_HS}, {11'h0, 12'hFFF, 1'b0});

      // Tiny mode: clamp of the leftover pixel, VSYNC lines, polarity, frame wrap.
      // (edges 9 and the VSYNC edges were already passed; restart checks below)
      @(negedge clk);
      #3 rst = 1'b1;
      #1;
      chk("async_reset_a", obs_a, {12'h000, 1'b0, 1'b0, 10'd0});
      chk("async_reset_c", obs_c, {12'h000, 1'b1, 1'b1, 10'd0});
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      wait_n(1);    chk("b_restart_white", {12'h0, obs_b[23:12]}, {12'h0, 12'hFFF});
                    chk("c_idle_high",     {22'h0, ifc.VGA_HS, ifc.VGA_VS}, 24'd3);
      wait_n(9);    chk("b_clamp_black",   {12'h0, obs_b[23:12]}, {12'h0, 12'h000});
      wait_n(11);   chk("c_hs_low",        {23'h0, ifc.VGA_HS}, 24'd0);
      wait_n(36);   chk("b_vs_before",     {23'h0, ifb.VGA_VS}, 24'd0);
      wait_n(37);   chk("b_vs_rise",       {23'h0, ifb.VGA_VS}, 24'd1);
                    chk("c_vs_low",        {23'h0, ifc.VGA_VS}, 24'd0);
      wait_n(48);   chk("b_vs_last",       {23'h0, ifb.VGA_VS}, 24'd1);
      wait_n(49);   chk("b_vs_fall",       {23'h0, ifb.VGA_VS}, 24'd0);
      wait_n(59);   chk("b_led_before",    {14'h0, ifb.LEDR}, 24'd0);
      wait_n(60);   chk("b_led_one",       {14'h0, ifb.LEDR}, 24'd1);
      wait_n(61);   chk("b_frame1_white",  {12'h0, obs_b[23:12]}, {12'h0, 12'hFFF});
      wait_n(61380); chk("b_led_1023",     {14'h0, ifb.LEDR}, 24'd1023);
      wait_n(61440); chk("b_led_wrap",     {14'h0, ifb.LEDR}, 24'd0);
      wait_n(61445);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
